pipe_ctrl: RTL

- Central sequencer for the fetch/decode/execute/translate/cache/writeback register chain.
- Generates per-stage write-enable and flush strobes for the stage registers, and allocates 3-bit reorder tags at fetch.
- Tracks tag completion from the fast (cache/writeback) path and the slow-instruction path, and retires tags in program order.
- Sits beside the datapath; takes hazard and miss indications and sources every stage `we`/`reset` strobe.

---
 rtl/pipe_pkg.sv | 11 +
 rtl/pipe_ctrl_if.sv | 47 ++++
 rtl/rob_tag_tracker.sv | 78 +++++++
 rtl/pipe_ctrl.sv | 112 +++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared constants, tag types and sequencer state encoding for the pipeline controller.
package pipe_pkg;
   localparam int unsigned ROB_IDX_W = 3;
   localparam int unsigned ROB_DEPTH = 1 << ROB_IDX_W;

   typedef logic [ROB_IDX_W-1:0] rob_idx_t;
   // Extra MSB is the wrap bit distinguishing full from empty.
   typedef logic [ROB_IDX_W:0]   rob_ptr_t;

   typedef enum logic [1:0] {RUN, DSTALL, REDIRECT} state_t;
endpackage

// File: rtl/pipe_ctrl_if.sv
// Hazard/completion inputs and stage strobe/tag outputs between datapath and sequencer.
interface pipe_ctrl_if;
   import pipe_pkg::*;

   logic     fetch_valid;
   logic     icache_miss;
   logic     load_use;
   logic     dcache_miss;
   logic     branch_taken;
   rob_idx_t branch_idx;
   logic     cmp_fast_valid;
   rob_idx_t cmp_fast_idx;
   logic     cmp_slow_valid;
   rob_idx_t cmp_slow_idx;

   logic     pc_we;
   logic     if_id_we;
   logic     id_ex_we;
   logic     ex_wbtl_we;
   logic     tl_c_we;
   logic     c_wb_we;
   logic     if_id_flush;
   logic     id_ex_flush;
   logic     c_wb_flush;
   rob_idx_t alloc_idx;
   logic     commit_valid;
   rob_idx_t commit_idx;
   logic     rob_full;
   logic     rob_empty;
   logic     cmp_err;

   modport master (
      output fetch_valid, icache_miss, load_use, dcache_miss, branch_taken, branch_idx,
             cmp_fast_valid, cmp_fast_idx, cmp_slow_valid, cmp_slow_idx,
      input  pc_we, if_id_we, id_ex_we, ex_wbtl_we, tl_c_we, c_wb_we,
             if_id_flush, id_ex_flush, c_wb_flush,
             alloc_idx, commit_valid, commit_idx, rob_full, rob_empty, cmp_err
   );

   modport slave (
      input  fetch_valid, icache_miss, load_use, dcache_miss, branch_taken, branch_idx,
             cmp_fast_valid, cmp_fast_idx, cmp_slow_valid, cmp_slow_idx,
      output pc_we, if_id_we, id_ex_we, ex_wbtl_we, tl_c_we, c_wb_we,
             if_id_flush, id_ex_flush, c_wb_flush,
             alloc_idx, commit_valid, commit_idx, rob_full, rob_empty, cmp_err
   );
endinterface

// File: rtl/rob_tag_tracker.sv
// Reorder-tag bookkeeping: allocation at fetch, two completion ports, in-order commit,
// branch squash and a sticky completion-protocol error flag.
module rob_tag_tracker
   import pipe_pkg::*;
(
   input  logic     clk,
   input  logic     reset,
   input  logic     alloc,
   input  logic     squash,
   input  rob_idx_t squash_idx,
   input  logic     fast_valid,
   input  rob_idx_t fast_idx,
   input  logic     slow_valid,
   input  rob_idx_t slow_idx,
   output rob_idx_t alloc_idx,
   output logic     commit_valid,
   output rob_idx_t commit_idx,
   output logic     full,
   output logic     empty,
   output logic     cmp_err
);
   rob_ptr_t             head, tail, count, tail_nxt, sq_off;
   logic [ROB_DEPTH-1:0] done, done_nxt;
   logic                 err_now;

   function automatic logic in_window(rob_idx_t idx, rob_ptr_t h, rob_ptr_t c);
      rob_ptr_t off;
      off = {1'b0, rob_idx_t'(idx - h[ROB_IDX_W-1:0])};
      return off < c;
   endfunction

   assign count        = tail - head;
   assign full         = (count == rob_ptr_t'(ROB_DEPTH));
   assign empty        = (count == '0);
   assign alloc_idx    = tail[ROB_IDX_W-1:0];
   assign commit_idx   = head[ROB_IDX_W-1:0];
   assign commit_valid = !empty && done[commit_idx];

   // Update order: completions set, squash clears, commit clears last.
   always_comb begin
      done_nxt = done;
      err_now  = 1'b0;
      tail_nxt = tail;
      sq_off   = {1'b0, rob_idx_t'(squash_idx - head[ROB_IDX_W-1:0])};
      if (fast_valid) begin
         if (in_window(fast_idx, head, count)) done_nxt[fast_idx] = 1'b1;
         else                                  err_now = 1'b1;
      end
      if (slow_valid) begin
         if (in_window(slow_idx, head, count)) done_nxt[slow_idx] = 1'b1;
         else                                  err_now = 1'b1;
      end
      if (fast_valid && slow_valid && (fast_idx == slow_idx)) err_now = 1'b1;
      if (squash && in_window(squash_idx, head, count)) begin
         tail_nxt = head + sq_off + rob_ptr_t'(1);
         for (int unsigned i = 0; i < ROB_DEPTH; i++) begin
            if (!in_window(rob_idx_t'(i), head, tail_nxt - head)) done_nxt[rob_idx_t'(i)] = 1'b0;
         end
      end else if (alloc) begin
         tail_nxt = tail + rob_ptr_t'(1);
      end
      if (commit_valid) done_nxt[commit_idx] = 1'b0;
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         head    <= '0;
         tail    <= '0;
         done    <= '0;
         cmp_err <= 1'b0;
      end else begin
         head <= head + rob_ptr_t'(commit_valid);
         tail <= tail_nxt;
         done <= done_nxt;
         if (err_now) cmp_err <= 1'b1;
      end
   end
endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: RUN/DSTALL/REDIRECT FSM, per-stage write-enable and flush decode,
// and the reorder-tag tracker.
module pipe_ctrl
   import pipe_pkg::*;
(
   input logic        clk,
   input logic        reset,
   pipe_ctrl_if.slave bus
);
   state_t   state;
   rob_idx_t br_idx_q;
   logic     hold, rob_full, alloc;
   logic     pc_we, if_id_we, id_ex_we, ex_wbtl_we, tl_c_we, c_wb_we;
   logic     if_id_flush, id_ex_flush, c_wb_flush;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= RUN;
         br_idx_q <= '0;
      end else begin
         case (state)
            RUN: begin
               if (bus.dcache_miss) state <= DSTALL;
               else if (bus.branch_taken) begin
                  state    <= REDIRECT;
                  br_idx_q <= bus.branch_idx;
               end
            end
            DSTALL:   if (!bus.dcache_miss) state <= RUN;
            REDIRECT: state <= bus.dcache_miss ? DSTALL : RUN;
            default:  state <= RUN;
         endcase
      end
   end

   assign hold = bus.load_use || rob_full;

   // Strobes are forced to the held/cleared pattern for as long as reset is low.
   always_comb begin
      pc_we       = 1'b0;
      if_id_we    = 1'b0;
      id_ex_we    = 1'b0;
      ex_wbtl_we  = 1'b0;
      tl_c_we     = 1'b0;
      c_wb_we     = 1'b0;
      if_id_flush = 1'b0;
      id_ex_flush = 1'b0;
      c_wb_flush  = 1'b0;
      case (state)
         RUN: begin
            pc_we       = !hold;
            if_id_we    = !hold;
            id_ex_we    = 1'b1;
            ex_wbtl_we  = 1'b1;
            tl_c_we     = 1'b1;
            c_wb_we     = 1'b1;
            id_ex_flush = bus.load_use;
            if_id_flush = !hold && (bus.icache_miss || !bus.fetch_valid);
         end
         DSTALL: begin
            c_wb_we    = 1'b1;
            c_wb_flush = 1'b1;
         end
         REDIRECT: begin
            pc_we       = 1'b1;
            if_id_we    = 1'b1;
            id_ex_we    = 1'b1;
            ex_wbtl_we  = 1'b1;
            tl_c_we     = 1'b1;
            c_wb_we     = 1'b1;
            if_id_flush = 1'b1;
            id_ex_flush = 1'b1;
         end
         default: ;
      endcase
      if (!reset) begin
         {pc_we, if_id_we, id_ex_we, ex_wbtl_we, tl_c_we, c_wb_we} = '0;
         {if_id_flush, id_ex_flush, c_wb_flush} = '1;
      end
   end

   assign alloc = (state == RUN) && pc_we && if_id_we && bus.fetch_valid && !bus.icache_miss && !rob_full;

   assign bus.pc_we       = pc_we;
   assign bus.if_id_we    = if_id_we;
   assign bus.id_ex_we    = id_ex_we;
   assign bus.ex_wbtl_we  = ex_wbtl_we;
   assign bus.tl_c_we     = tl_c_we;
   assign bus.c_wb_we     = c_wb_we;
   assign bus.if_id_flush = if_id_flush;
   assign bus.id_ex_flush = id_ex_flush;
   assign bus.c_wb_flush  = c_wb_flush;
   assign bus.rob_full    = rob_full;

   rob_tag_tracker u_tracker (
      .clk          (clk),
      .reset        (reset),
      .alloc        (alloc),
      .squash       (state == REDIRECT),
      .squash_idx   (br_idx_q),
      .fast_valid   (bus.cmp_fast_valid),
      .fast_idx     (bus.cmp_fast_idx),
      .slow_valid   (bus.cmp_slow_valid),
      .slow_idx     (bus.cmp_slow_idx),
      .alloc_idx    (bus.alloc_idx),
      .commit_valid (bus.commit_valid),
      .commit_idx   (bus.commit_idx),
      .full         (rob_full),
      .empty        (bus.rob_empty),
      .cmp_err      (bus.cmp_err)
   );
endmodule
